// File: rtl/uart_rx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_if
// Byte-stream handshake between the UART receiver and its consumer.
//   data_out   : received byte, stable while data_valid is high
//   data_valid : buffer holds an unconsumed byte
//   data_ready : consumer takes the byte on a data_valid && data_ready cycle
// master = the receiver (produces bytes), slave = the consumer.
// ---------------------------------------------------------------------------
interface uart_rx_frame_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
// 8N1 UART receiver with 3-sample mid-bit majority voting and a one-entry
// valid/ready output buffer.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   uart_rxd   : asynchronous serial input, idles high
//   bus        : byte handshake (data_out / data_valid / data_ready), master
//   frame_err  : 1-cycle pulse, stop bit sampled low (byte discarded)
//   overrun    : 1-cycle pulse, good byte dropped because buffer was full
//   busy       : high in START, DATA and STOP
// ---------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int BIT_CNT  = CLK_FREQ / BAUD,
  parameter int HALF     = BIT_CNT / 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rxd,
  uart_rx_frame_if.master    bus,
  output logic               frame_err,
  output logic               overrun,
  output logic               busy
);

  localparam int CW = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_S2   = CW'(HALF + 1);

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [1:0]      smp;
  logic [7:0]      shreg;

  logic            sync_q;
  logic            rx_s;
  logic            rx_d;

  // NOTE: the synchroniser resets to the idle (high) level so that releasing
  // reset can never look like a falling edge / start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= uart_rxd;
      rx_s   <= sync_q;
      rx_d   <= rx_s;
    end
  end

  logic       fall;
  logic       mid;
  logic       sample_en;
  logic [2:0] votes;
  logic       maj;

  assign fall      = rx_d && !rx_s;
  assign mid       = (cnt == CNT_S2);
  assign sample_en = (cnt == CNT_S0) || (cnt == CNT_S1);
  // smp holds the samples from HALF-1 and HALF; the third vote is rx_s
  // itself, taken live in the HALF+1 decision cycle.
  assign votes     = {smp, rx_s};
  assign maj       = (votes[0] & votes[1]) | (votes[0] & votes[2]) |
                     (votes[1] & votes[2]);

  // NOTE: all state below uses non-blocking assignments; later assignments in
  // the same cycle override earlier defaults (e.g. a load beats a handshake).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ARM;
      cnt            <= '0;
      bit_idx        <= '0;
      smp            <= '0;
      shreg          <= '0;
      bus.data_out   <= 8'h00;
      bus.data_valid <= 1'b0;
      frame_err      <= 1'b0;
      overrun        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (sample_en) begin
        smp <= {smp[0], rx_s};
      end

      if (bus.data_valid && bus.data_ready) begin
        bus.data_valid <= 1'b0;
      end

      case (state)
        // Wait for a full bit time of continuous idle so a reset or framing
        // error in mid-frame cannot lock onto a data-bit edge.
        ARM: begin
          if (!rx_s) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        IDLE: begin
          if (fall) begin
            cnt   <= '0;
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (mid && maj) begin
            // Line back high at mid-start: glitch, not a frame.
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (mid) begin
            shreg[bit_idx] <= maj;
          end
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Decide at mid-stop and leave immediately, so a fast transmitter's
        // next start bit is not missed.
        STOP: begin
          if (mid) begin
            cnt  <= '0;
            busy <= 1'b0;
            if (maj) begin
              state <= IDLE;
              if (!bus.data_valid || bus.data_ready) begin
                bus.data_out   <= shreg;
                bus.data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ARM;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= ARM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
// Directed bench for uart_rx_frame at default parameters (434 clocks/bit).
// Serial frames are driven on the falling clock edge, one bit every BIT_CNT
// clocks; a monitor on the falling edge logs accepted bytes and flag pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

  localparam int B    = 434;
  localparam int HALF = 217;
  // Fall of uart_rxd to first data_valid cycle: 3 sync/edge clocks + 4125.
  localparam int LAT  = 3 + 9 * B + HALF + 2;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic uart_rxd = 1'b1;
  logic frame_err;
  logic overrun;
  logic busy;

  uart_rx_frame_if bus ();

  uart_rx_frame dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .bus       (bus.master),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  logic [7:0] rx_log [0:63];
  int   rx_n           = 0;
  int   fe_cnt         = 0;
  int   ov_cnt         = 0;
  int   both_cnt       = 0;
  int   valid_cycles   = 0;
  int   valid_rise_cyc = -1;
  int   gap_last       = 0;
  int   low_run        = 0;
  logic prev_valid     = 1'b0;

  always @(negedge clk) begin
    if (bus.data_valid && bus.data_ready && rx_n < 64) begin
      rx_log[rx_n] = bus.data_out;
      rx_n++;
    end
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
    if (bus.data_valid) valid_cycles++;
    if (bus.data_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = bus.data_valid;
    if (busy) begin
      if (low_run > 0) gap_last = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  int last_fall = 0;

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (B) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    last_fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  int n0, fe0, ov0, vc0;

  task automatic snap();
    n0  = rx_n;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    vc0 = valid_cycles;
  endtask

  initial begin
    bus.data_ready = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_data_out",  bus.data_out, 8'h00);
    check("rst_valid",     bus.data_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun",   overrun, 1'b0);
    check("rst_busy",      busy, 1'b0);
    rst = 1'b0;
    repeat (B + 20) @(negedge clk);

    // Single frame 0xC9
    bus.data_ready = 1'b1;
    snap();
    send_frame(8'hC9, 1'b1);
    check("single_count", rx_n - n0, 1);
    check("single_byte", rx_log[n0], 8'hC9);
    check("single_latency_window",
          ((valid_rise_cyc - last_fall) >= LAT - 1) &&
          ((valid_rise_cyc - last_fall) <= LAT + 1), 1'b1);
    check("single_valid_width", valid_cycles - vc0, 1);
    check("single_no_fe", fe_cnt - fe0, 0);
    check("single_no_ov", ov_cnt - ov0, 0);
    repeat (20) @(negedge clk);

    // Back-to-back 0xC9, 0x93
    snap();
    send_frame(8'hC9, 1'b1);
    send_frame(8'h93, 1'b1);
    check("b2b_count", rx_n - n0, 2);
    check("b2b_byte0", rx_log[n0], 8'hC9);
    check("b2b_byte1", rx_log[n0 + 1], 8'h93);
    check("b2b_gap_lt_half", (gap_last > 0) && (gap_last < HALF), 1'b1);
    check("b2b_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    repeat (20) @(negedge clk);

    // Glitch: 100 clocks low enters START, rejected at mid-start
    snap();
    uart_rxd = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_start_busy", busy, 1'b1);
    repeat (90) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_back_idle", busy, 1'b0);
    repeat (B) @(negedge clk);
    check("glitch_no_valid", valid_cycles - vc0, 0);
    check("glitch_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // Framing error on 0x55, line low 2 bits, then 0xA5
    snap();
    send_frame(8'h55, 1'b0);
    repeat (B) @(negedge clk);
    check("fe_arm_not_busy", busy, 1'b0);
    repeat (B) @(negedge clk);
    check("fe_pulse_once", fe_cnt - fe0, 1);
    check("fe_no_valid", valid_cycles - vc0, 0);
    uart_rxd = 1'b1;
    repeat (B + 20) @(negedge clk);
    send_frame(8'hA5, 1'b1);
    check("fe_next_count", rx_n - n0, 1);
    check("fe_next_byte", rx_log[n0], 8'hA5);
    check("fe_no_extra_fe", fe_cnt - fe0, 1);
    repeat (20) @(negedge clk);

    // Overrun: data_ready low, 0x11 then 0x22
    bus.data_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("ov_data_held", bus.data_out, 8'h11);
    check("ov_valid_held", bus.data_valid, 1'b1);
    check("ov_pulse_once", ov_cnt - ov0, 1);
    check("ov_no_fe", fe_cnt - fe0, 0);
    @(posedge clk);
    #2 bus.data_ready = 1'b1;
    @(posedge clk);
    #2 bus.data_ready = 1'b0;
    @(negedge clk);
    check("ov_valid_cleared", bus.data_valid, 1'b0);
    check("ov_accepted_byte", rx_log[rx_n - 1], 8'h11);
    repeat (20) @(negedge clk);

    // Reset during data bit 4 of 0xC9
    bus.data_ready = 1'b1;
    snap();
    fork
      send_frame(8'hC9, 1'b1);
      begin
        repeat (5 * B + B / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_data_out", bus.data_out, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", bus.data_valid, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("midrst_no_valid", valid_cycles - vc0, 0);
    check("midrst_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    send_frame(8'h3C, 1'b1);
    check("midrst_next_count", rx_n - n0, 1);
    check("midrst_next_byte", rx_log[n0], 8'h3C);

    check("flags_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
